// File: rtl/fibonacci_generator_if.sv
// Term-stream and control interface of the Fibonacci generator.
interface fibonacci_generator_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDXW  = 6
);
  logic             START;
  logic [IDXW-1:0]  K;
  logic             READY;
  logic [WIDTH-1:0] TERM;
  logic [IDXW-1:0]  TERM_IDX;
  logic             TERM_VALID;
  logic [WIDTH-1:0] F_OUT;
  logic             OVF;
  logic             BUSY;
  logic             DONE;

  // Requester side: issues runs and consumes terms.
  modport master (
    output START, K, READY,
    input  TERM, TERM_IDX, TERM_VALID, F_OUT, OVF, BUSY, DONE
  );

  // Generator side.
  modport slave (
    input  START, K, READY,
    output TERM, TERM_IDX, TERM_VALID, F_OUT, OVF, BUSY, DONE
  );
endinterface

// File: rtl/fibonacci_generator.sv
// Streams F(0)..F(K) over a valid/ready interface and reports F(K),
// flagging terms that do not fit in WIDTH bits.
module fibonacci_generator #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDXW  = 6
) (
  input  logic                  CLK,
  input  logic                  RESET,
  fibonacci_generator_if.slave  bus
);

  localparam int unsigned SUMW = WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EMIT,
    S_STEP,
    S_FINISH
  } state_e;

  state_e           state_q,      state_d;
  logic [WIDTH-1:0] a_q,          a_d;
  logic [WIDTH-1:0] b_q,          b_d;
  logic             a_ovf_q,      a_ovf_d;
  logic             b_ovf_q,      b_ovf_d;
  logic [IDXW-1:0]  idx_q,        idx_d;
  logic [IDXW-1:0]  k_reg_q,      k_reg_d;
  logic [WIDTH-1:0] term_q,       term_d;
  logic [IDXW-1:0]  term_idx_q,   term_idx_d;
  logic             term_valid_q, term_valid_d;
  logic [WIDTH-1:0] f_out_q,      f_out_d;
  logic             ovf_q,        ovf_d;
  logic             busy_q,       busy_d;
  logic             done_q,       done_d;
  logic [SUMW-1:0]  sum_c;

  // State and output registers, cleared asynchronously.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      a_ovf_q      <= 1'b0;
      b_ovf_q      <= 1'b0;
      idx_q        <= '0;
      k_reg_q      <= '0;
      term_q       <= '0;
      term_idx_q   <= '0;
      term_valid_q <= 1'b0;
      f_out_q      <= '0;
      ovf_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      a_ovf_q      <= a_ovf_d;
      b_ovf_q      <= b_ovf_d;
      idx_q        <= idx_d;
      k_reg_q      <= k_reg_d;
      term_q       <= term_d;
      term_idx_q   <= term_idx_d;
      term_valid_q <= term_valid_d;
      f_out_q      <= f_out_d;
      ovf_q        <= ovf_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Next-state and next-output logic; outputs are set up one edge ahead
  // so that every visible output comes straight from a flop.
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    a_ovf_d      = a_ovf_q;
    b_ovf_d      = b_ovf_q;
    idx_d        = idx_q;
    k_reg_d      = k_reg_q;
    term_d       = term_q;
    term_idx_d   = term_idx_q;
    term_valid_d = term_valid_q;
    f_out_d      = f_out_q;
    ovf_d        = ovf_q;
    busy_d       = busy_q;
    done_d       = done_q;
    sum_c        = SUMW'(a_q) + SUMW'(b_q);

    unique case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          k_reg_d      = bus.K;
          a_d          = '0;
          b_d          = WIDTH'(1);
          a_ovf_d      = 1'b0;
          b_ovf_d      = 1'b0;
          idx_d        = '0;
          done_d       = 1'b0;
          ovf_d        = 1'b0;
          busy_d       = 1'b1;
          term_valid_d = 1'b1;
          term_d       = '0;
          term_idx_d   = '0;
          state_d      = S_EMIT;
        end
      end

      S_EMIT: begin
        if (term_valid_q && bus.READY) begin
          term_valid_d = 1'b0;
          state_d      = (idx_q == k_reg_q) ? S_FINISH : S_STEP;
        end
      end

      S_STEP: begin
        // b may hold a wrapped value; that only matters once it becomes a.
        a_d     = b_q;
        a_ovf_d = b_ovf_q;
        b_d     = sum_c[WIDTH-1:0];
        b_ovf_d = sum_c[WIDTH] | a_ovf_q | b_ovf_q;
        idx_d   = idx_q + IDXW'(1);
        if (b_ovf_q) begin
          ovf_d   = 1'b1;
          state_d = S_FINISH;
        end else begin
          term_valid_d = 1'b1;
          term_d       = b_q;
          term_idx_d   = idx_q + IDXW'(1);
          state_d      = S_EMIT;
        end
      end

      S_FINISH: begin
        f_out_d = ovf_q ? '0 : a_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.TERM       = term_q;
  assign bus.TERM_IDX   = term_idx_q;
  assign bus.TERM_VALID = term_valid_q;
  assign bus.F_OUT      = f_out_q;
  assign bus.OVF        = ovf_q;
  assign bus.BUSY       = busy_q;
  assign bus.DONE       = done_q;

endmodule

// File: tb/tb_fibonacci_generator.sv
// Scoreboard bench for fibonacci_generator.
module tb_fibonacci_generator;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned IDXW  = 6;

  typedef struct packed {
    logic [WIDTH-1:0] term;
    logic [IDXW-1:0]  idx;
  } xfer_t;

  logic  CLK   = 1'b0;
  logic  RESET = 1'b1;
  xfer_t exp_q[$];
  int    n_tests       = 0;
  int    n_fail        = 0;
  int    cyc           = 0;
  int    last_xfer_cyc = 0;

  // Monitor state
  xfer_t            mon_e;
  logic             mon_stall = 1'b0;
  logic [WIDTH-1:0] mon_term  = '0;
  logic [IDXW-1:0]  mon_idx   = '0;

  fibonacci_generator_if #(.WIDTH(WIDTH), .IDXW(IDXW)) bus ();

  fibonacci_generator #(.WIDTH(WIDTH), .IDXW(IDXW)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] fib(input int n);
    logic [63:0] a = 64'd0;
    logic [63:0] b = 64'd1;
    logic [63:0] t;
    for (int i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_term"},       64'(bus.TERM),       64'd0);
    check({tag, "_term_idx"},   64'(bus.TERM_IDX),   64'd0);
    check({tag, "_term_valid"}, 64'(bus.TERM_VALID), 64'd0);
    check({tag, "_f_out"},      64'(bus.F_OUT),      64'd0);
    check({tag, "_ovf"},        64'(bus.OVF),        64'd0);
    check({tag, "_busy"},       64'(bus.BUSY),       64'd0);
    check({tag, "_done"},       64'(bus.DONE),       64'd0);
  endtask

  // Pops the scoreboard on every transfer and checks stability while stalled.
  initial forever begin
    @(negedge CLK);
    if (RESET) begin
      mon_stall = 1'b0;
    end else begin
      if (mon_stall) begin
        check("hold_valid", 64'(bus.TERM_VALID), 64'd1);
        check("hold_term",  64'(bus.TERM),       64'(mon_term));
        check("hold_idx",   64'(bus.TERM_IDX),   64'(mon_idx));
      end
      if (bus.TERM_VALID && bus.READY) begin
        check("sb_avail", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("term",     64'(bus.TERM),     64'(mon_e.term));
          check("term_idx", 64'(bus.TERM_IDX), 64'(mon_e.idx));
        end
        last_xfer_cyc = cyc;
      end
      mon_stall = bus.TERM_VALID && !bus.READY;
      mon_term  = bus.TERM;
      mon_idx   = bus.TERM_IDX;
    end
  end

  task automatic start_run(input int k);
    int last;
    xfer_t e;
    last = (k > 47) ? 47 : k;
    for (int i = 0; i <= last; i++) begin
      e.term = WIDTH'(fib(i));
      e.idx  = IDXW'(i);
      exp_q.push_back(e);
    end
    @(posedge CLK); #1;
    bus.START = 1'b1;
    bus.K     = IDXW'(k);
    @(posedge CLK); #1;
    bus.START = 1'b0;
    check("accept_busy",  64'(bus.BUSY),       64'd1);
    check("accept_done",  64'(bus.DONE),       64'd0);
    check("accept_ovf",   64'(bus.OVF),        64'd0);
    check("first_valid",  64'(bus.TERM_VALID), 64'd1);
  endtask

  task automatic wait_xfer(input int idx);
    int n = 0;
    while (n < 400) begin
      @(negedge CLK);
      if (bus.TERM_VALID && bus.READY && (int'(bus.TERM_IDX) == idx)) break;
      n++;
    end
    check("wait_xfer_timeout", 64'(n < 400), 64'd1);
  endtask

  task automatic wait_done(input logic [63:0] exp_f, input logic exp_ovf, input int lat);
    int n = 0;
    while (n < 400) begin
      @(negedge CLK);
      if (bus.DONE) break;
      n++;
    end
    check("done_timeout", 64'(bus.DONE),       64'd1);
    check("f_out",        64'(bus.F_OUT),      exp_f);
    check("ovf",          64'(bus.OVF),        64'(exp_ovf));
    check("busy_idle",    64'(bus.BUSY),       64'd0);
    check("valid_idle",   64'(bus.TERM_VALID), 64'd0);
    check("sb_drained",   64'(exp_q.size()),   64'd0);
    check("done_latency", 64'(cyc - last_xfer_cyc), 64'(lat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.START = 1'b0;
    bus.K     = '0;
    bus.READY = 1'b1;
    RESET     = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check_all_zero("reset");
    RESET = 1'b0;

    // Single term
    start_run(0);
    wait_done(64'd0, 1'b0, 2);

    // Full-rate stream
    start_run(10);
    wait_done(64'd55, 1'b0, 2);

    // Back-pressure while idx 3 is presented
    start_run(5);
    wait_xfer(2);
    @(posedge CLK); #1;
    bus.READY = 1'b0;
    @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("stall_valid", 64'(bus.TERM_VALID), 64'd1);
      check("stall_term",  64'(bus.TERM),       64'd2);
      check("stall_idx",   64'(bus.TERM_IDX),   64'd3);
    end
    @(posedge CLK); #1;
    bus.READY = 1'b1;
    wait_done(64'd5, 1'b0, 2);

    // Largest representable term, then first overflowing index
    start_run(47);
    wait_done(64'd2971215073, 1'b0, 2);
    start_run(48);
    wait_done(64'd0, 1'b1, 3);

    // Restart after an overflowed run clears DONE and OVF
    start_run(1);
    wait_done(64'd1, 1'b0, 2);

    // Maximum index terminates through overflow
    start_run(63);
    wait_done(64'd0, 1'b1, 3);

    // START while busy is ignored
    start_run(20);
    wait_xfer(4);
    @(posedge CLK); #1;
    bus.START = 1'b1;
    bus.K     = IDXW'(3);
    @(posedge CLK); #1;
    bus.START = 1'b0;
    wait_done(64'd6765, 1'b0, 2);

    // Asynchronous reset mid-run
    start_run(20);
    wait_xfer(4);
    #2;
    RESET = 1'b1;
    #1;
    check_all_zero("midrun_reset");
    exp_q.delete();
    @(posedge CLK); #1;
    check("reset_hold_busy", 64'(bus.BUSY), 64'd0);
    RESET = 1'b0;

    start_run(2);
    wait_done(64'd1, 1'b0, 2);

    repeat (2) @(posedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
